// File: rtl/draw_sequencer_if.sv
// Frame-controller bus: host request/status, both engine handshakes and the VGA plot port.
// master = the sequencer, slave = the host/engine/adapter side.
interface draw_sequencer_if;
    logic       start;
    logic       skip_clear;
    logic [2:0] bg_colour;
    logic       done;
    logic       error;

    logic       fill_start;
    logic [2:0] fill_colour;
    logic       fill_done;
    logic [7:0] fill_x;
    logic [6:0] fill_y;
    logic [2:0] fill_vcol;
    logic       fill_plot;

    logic       shape_start;
    logic       shape_done;
    logic [7:0] shape_x;
    logic [6:0] shape_y;
    logic [2:0] shape_vcol;
    logic       shape_plot;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        input  start, skip_clear, bg_colour,
        input  fill_done, fill_x, fill_y, fill_vcol, fill_plot,
        input  shape_done, shape_x, shape_y, shape_vcol, shape_plot,
        output done, error, fill_start, fill_colour, shape_start,
        output vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        output start, skip_clear, bg_colour,
        output fill_done, fill_x, fill_y, fill_vcol, fill_plot,
        output shape_done, shape_x, shape_y, shape_vcol, shape_plot,
        input  done, error, fill_start, fill_colour, shape_start,
        input  vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/draw_sequencer.sv
// Frame controller: clear the screen with fillscreen, then run one shape engine,
// owning the VGA plot port and guarding each phase with a watchdog.
module draw_sequencer #(
    parameter int             CNT_W   = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = 16'd40000
) (
    input  logic              clk,
    input  logic              rst_n,
    draw_sequencer_if.master  bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, GAP, DRAW, FIN, ERR} state_t;

    localparam logic [CNT_W-1:0] LAST = TIMEOUT - {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_next;
    logic [CNT_W-1:0] wdog, wdog_next, wdog_inc;
    logic [2:0]       colour, colour_next;
    logic             expired;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            wdog   <= '0;
            colour <= '0;
        end else begin
            state  <= state_next;
            wdog   <= wdog_next;
            colour <= colour_next;
        end
    end

    // Saturating so a stuck phase can never wrap back below LAST.
    assign wdog_inc = (wdog == {CNT_W{1'b1}}) ? wdog : wdog + 1'b1;
    assign expired  = (wdog == LAST);

    // Priority in every active phase: abort, then the engine's done, then the watchdog.
    always_comb begin
        state_next  = state;
        wdog_next   = wdog;
        colour_next = colour;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    colour_next = bus.bg_colour;
                    wdog_next   = '0;
                    state_next  = bus.skip_clear ? DRAW : CLEAR;
                end
            end
            CLEAR: begin
                wdog_next = wdog_inc;
                if (!bus.start)         begin state_next = IDLE; wdog_next = '0; end
                else if (bus.fill_done) state_next = GAP;
                else if (expired)       state_next = ERR;
            end
            GAP: begin
                wdog_next = wdog_inc;
                if (!bus.start)          begin state_next = IDLE; wdog_next = '0; end
                else if (!bus.fill_done) begin state_next = DRAW; wdog_next = '0; end
                else if (expired)        state_next = ERR;
            end
            DRAW: begin
                wdog_next = wdog_inc;
                if (!bus.start)          begin state_next = IDLE; wdog_next = '0; end
                else if (bus.shape_done) state_next = FIN;
                else if (expired)        state_next = ERR;
            end
            FIN, ERR: begin
                if (!bus.start) begin
                    state_next = IDLE;
                    wdog_next  = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.fill_start  = (state == CLEAR);
    assign bus.shape_start = (state == DRAW);
    assign bus.done        = (state == FIN);
    assign bus.error       = (state == ERR);
    assign bus.fill_colour = colour;

    // Only the engine owning the current phase reaches the adapter.
    always_comb begin
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        bus.vga_plot   = 1'b0;
        if (state == CLEAR) begin
            bus.vga_x      = bus.fill_x;
            bus.vga_y      = bus.fill_y;
            bus.vga_colour = bus.fill_vcol;
            bus.vga_plot   = bus.fill_plot;
        end else if (state == DRAW) begin
            bus.vga_x      = bus.shape_x;
            bus.vga_y      = bus.shape_y;
            bus.vga_colour = bus.shape_vcol;
            bus.vga_plot   = bus.shape_plot;
        end
    end
endmodule
